rotator_seq: RTL

Parametrised sequential rotate/shift unit, the multi-bit successor of the fixed 4-bit one-position right rotator.
- Moves one bit position per enabled clock, for a run-time amount.
- Runtime direction: left or right.
- Runtime mode: rotate, logical shift or arithmetic shift.
- Handshake: start/busy/done.
- Sits between operand registers and the result bus in the datapath test harness.

---
 rtl/rot_pkg.sv | 17 +
 rtl/rot_step.sv | 42 ++++
 rtl/rotator_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/rot_pkg.sv
// Shared encodings for the sequential rotate/shift unit: operation modes,
// direction values and FSM states.
package rot_pkg;

   localparam logic [1:0] MODE_ROT = 2'b00;
   localparam logic [1:0] MODE_LSH = 2'b01;
   localparam logic [1:0] MODE_ASH = 2'b10;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/rot_step.sv
// One-position rotate/shift of a WIDTH-bit word, purely combinational.
module rot_step
   import rot_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] s,
   input  logic             dir,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] y
);

   logic fill_right;
   logic fill_left;

   always_comb begin
      // Bit entering at the MSB on a right move, and at the LSB on a left move.
      fill_right = s[0];
      fill_left  = s[WIDTH-1];
      case (mode)
         MODE_LSH: begin
            fill_right = 1'b0;
            fill_left  = 1'b0;
         end
         MODE_ASH: begin
            fill_right = s[WIDTH-1];
            fill_left  = 1'b0;
         end
         default: begin
            fill_right = s[0];
            fill_left  = s[WIDTH-1];
         end
      endcase

      if (dir == DIR_LEFT) begin
         y = {s[WIDTH-2:0], fill_left};
      end else begin
         y = {fill_right, s[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/rotator_seq.sv
// Sequential rotate/shift unit: accepts an operand, moves it one position per
// enabled clock for a run-time amount, then publishes the result with a done pulse.
module rotator_seq
   import rot_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int AMT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             enable,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   state_t           state_reg,  state_next;
   logic [WIDTH-1:0] shreg_reg,  shreg_next;
   logic [AMT_W-1:0] count_reg,  count_next;
   logic             dir_reg,    dir_next;
   logic [1:0]       mode_reg,   mode_next;
   logic [WIDTH-1:0] dout_reg,   dout_next;
   logic             done_reg,   done_next;
   logic [WIDTH-1:0] stepped;

   rot_step #(.WIDTH(WIDTH)) u_step (
      .s    (shreg_reg),
      .dir  (dir_reg),
      .mode (mode_reg),
      .y    (stepped)
   );

   always_comb begin
      state_next = state_reg;
      shreg_next = shreg_reg;
      count_next = count_reg;
      dir_next   = dir_reg;
      mode_next  = mode_reg;
      dout_next  = dout_reg;
      done_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               shreg_next = din;
               count_next = amt;
               dir_next   = dir;
               mode_next  = mode;
               state_next = RUN;
            end
         end
         RUN: begin
            // Completion does not wait for enable once all steps are done.
            if (count_reg == '0) begin
               dout_next  = shreg_reg;
               done_next  = 1'b1;
               state_next = IDLE;
            end else if (enable) begin
               shreg_next = stepped;
               count_next = count_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         shreg_reg <= '0;
         count_reg <= '0;
         dir_reg   <= DIR_RIGHT;
         mode_reg  <= MODE_ROT;
         dout_reg  <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         shreg_reg <= shreg_next;
         count_reg <= count_next;
         dir_reg   <= dir_next;
         mode_reg  <= mode_next;
         dout_reg  <= dout_next;
         done_reg  <= done_next;
      end
   end

   assign dout = dout_reg;
   assign busy = (state_reg == RUN);
   assign done = done_reg;

endmodule
